multi_clk_divider: RTL and testbench

- Parametrised N-channel clock divider and blinker for board bring-up and status LEDs.
- All channels run from one system clock; no per-channel clock inputs.
- Each channel has a run-time divisor, enable and mode.
- Adds glitch-free divisor reload, a one-cycle tick output and a global phase-align strobe, so the dividers also serve as timebases, not only LED drivers.

---
 rtl/multi_clk_divider.sv | 104 ++++++++++
 tb/tb_multi_clk_divider.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multi_clk_divider.sv
// multi_clk_divider
//   N independent programmable clock dividers / blinkers sharing one system
//   clock. Each channel counts enabled cycles up to its terminal count and
//   then emits a one-cycle tick and flips its toggle flop. The divisor is
//   double-buffered so that a run-time change never produces a short or
//   long glitch period. A global sync strobe restarts every channel in phase.
//
// Ports
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   sync_i  phase-align strobe, restarts all channels together
//   en_i    per-channel count enable
//   mode_i  per-channel mode: 0 = toggle (square wave), 1 = pulse
//   load_i  per-channel divisor load strobe
//   div_i   packed divisors, channel k at [k*WIDTH +: WIDTH]
//   sig_o   registered divided output (LED drive)
//   tick_o  registered one-cycle strobe at each terminal count
module multi_clk_divider #(
  parameter int CHANNELS    = 3,
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = 50000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sync_i,
  input  logic [CHANNELS-1:0]       en_i,
  input  logic [CHANNELS-1:0]       mode_i,
  input  logic [CHANNELS-1:0]       load_i,
  input  logic [CHANNELS*WIDTH-1:0] div_i,
  output logic [CHANNELS-1:0]       sig_o,
  output logic [CHANNELS-1:0]       tick_o
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi = gi + 1) begin : g_ch
      logic [WIDTH-1:0] cnt_reg;
      logic [WIDTH-1:0] act_reg;
      logic [WIDTH-1:0] shd_reg;
      logic             tgl_reg;
      logic             tick_reg;
      logic             sig_reg;

      logic [WIDTH-1:0] div_w;
      logic [WIDTH-1:0] term_w;
      logic [WIDTH-1:0] shd_next;
      logic             term_hit;

      assign div_w = div_i[gi*WIDTH +: WIDTH];

      // A divisor of 0 behaves like 1, so the terminal count saturates at 0.
      assign term_w = (act_reg == '0) ? '0 : act_reg - 1'b1;

      // Shadow value as it will be after this edge; also the source for the
      // active divisor on a terminal/sync edge, which gives the load bypass.
      assign shd_next = load_i[gi] ? div_w : shd_reg;

      // act only changes when cnt returns to 0, so cnt can never be beyond
      // the terminal count and never wraps through 2^WIDTH.
      assign term_hit = en_i[gi] && (cnt_reg == term_w);

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg  <= '0;
          act_reg  <= DEF_DIV;
          shd_reg  <= DEF_DIV;
          tgl_reg  <= 1'b0;
          tick_reg <= 1'b0;
          sig_reg  <= 1'b0;
        end else if (sync_i) begin
          cnt_reg  <= '0;
          act_reg  <= shd_next;
          shd_reg  <= shd_next;
          tgl_reg  <= 1'b0;
          tick_reg <= 1'b0;
          sig_reg  <= 1'b0;
        end else begin
          shd_reg <= shd_next;
          if (term_hit) begin
            cnt_reg  <= '0;
            act_reg  <= shd_next;
            tick_reg <= 1'b1;
            // Pulse mode pins tgl low so toggle mode always restarts low.
            tgl_reg  <= ~tgl_reg & ~mode_i[gi];
            sig_reg  <= mode_i[gi] ? 1'b1 : ~tgl_reg;
          end else begin
            if (en_i[gi]) begin
              cnt_reg <= cnt_reg + 1'b1;
            end
            tick_reg <= 1'b0;
            tgl_reg  <= tgl_reg & ~mode_i[gi];
            sig_reg  <= mode_i[gi] ? 1'b0 : tgl_reg;
          end
        end
      end

      assign sig_o[gi]  = sig_reg;
      assign tick_o[gi] = tick_reg;
    end
  endgenerate

endmodule

// File: tb/tb_multi_clk_divider.sv
// Directed bench for multi_clk_divider with CHANNELS=3, WIDTH=8,
// DEFAULT_DIV=4. "cyc" counts rising edges since the current reset release;
// all inputs are driven and outputs sampled 1 time unit after a rising edge.
module tb_multi_clk_divider;

  localparam int CH = 3;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sync_i;
  logic [CH-1:0] en_i;
  logic [CH-1:0] mode_i;
  logic [CH-1:0] load_i;
  logic [CH*W-1:0] div_i;
  logic [CH-1:0] sig_o;
  logic [CH-1:0] tick_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int s_cyc        = 0;

  multi_clk_divider #(
    .CHANNELS   (CH),
    .WIDTH      (W),
    .DEFAULT_DIV(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sync_i(sync_i),
    .en_i  (en_i),
    .mode_i(mode_i),
    .load_i(load_i),
    .div_i (div_i),
    .sig_o (sig_o),
    .tick_o(tick_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [2:0] exp_t;
    logic [2:0] exp_s;
    int k;

    rst    = 1'b1;
    sync_i = 1'b0;
    en_i   = 3'b111;
    mode_i = 3'b000;
    load_i = 3'b000;
    div_i  = '0;

    // Outputs stay low for the whole reset even with enables high.
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rst_tick", 32'(tick_o), 32'h0);
      check_val("rst_sig", 32'(sig_o), 32'h0);
    end
    rst = 1'b0;
    cyc = 0;
    $display("[TB] phase 1: toggle mode, default divisor 4");

    // First tick in cycle 4, square wave period 8.
    while (cyc < 8) begin
      step();
      exp_t = (cyc % 4 == 0) ? 3'b111 : 3'b000;
      exp_s = ((cyc / 4) % 2 == 1) ? 3'b111 : 3'b000;
      check_val("p1_tick", 32'(tick_o), 32'(exp_t));
      check_val("p1_sig", 32'(sig_o), 32'(exp_s));
    end

    $display("[TB] phase 2: channel 1 pulse mode");
    mode_i = 3'b010;
    while (cyc < 16) begin
      step();
      exp_t = (cyc % 4 == 0) ? 3'b111 : 3'b000;
      exp_s = ((cyc / 4) % 2 == 1) ? 3'b101 : 3'b000;
      exp_s[1] = (cyc % 4 == 0);
      check_val("p2_tick", 32'(tick_o), 32'(exp_t));
      check_val("p2_sig", 32'(sig_o), 32'(exp_s));
    end
    mode_i = 3'b000;

    $display("[TB] phase 3: mid-period and terminal-coincident loads on channel 2");
    while (cyc < 60) begin
      load_i = 3'b000;
      if (cyc == 17) begin
        load_i = 3'b100;
        div_i[2*W +: W] = 8'd10;
      end
      if (cyc == 49) begin
        load_i = 3'b100;
        div_i[2*W +: W] = 8'd5;
      end
      step();
      if (cyc >= 18) begin
        exp_t = (cyc % 4 == 0) ? 3'b011 : 3'b000;
        exp_t[2] = (cyc == 20 || cyc == 30 || cyc == 40 || cyc == 50 ||
                    cyc == 55 || cyc == 60);
        check_val("p3_tick", 32'(tick_o), 32'(exp_t));
      end
    end
    load_i = 3'b000;

    $display("[TB] phase 4: divisors 0 and 1 on channels 0 and 1");
    load_i = 3'b011;
    div_i[0 +: W] = 8'd0;
    div_i[W +: W] = 8'd1;
    step();
    load_i = 3'b000;
    while (cyc < 72) begin
      step();
      exp_t = (cyc >= 64) ? 3'b011 : 3'b000;
      exp_t[2] = (cyc % 5 == 0);
      check_val("p4_tick", 32'(tick_o), 32'(exp_t));
      if (cyc >= 64) begin
        exp_s = (cyc % 2 == 1) ? 3'b011 : 3'b000;
        check_val("p4_sig", 32'(sig_o[1:0]), 32'(exp_s[1:0]));
      end
    end

    $display("[TB] phase 5: channel 0 enable gap");
    while (cyc < 82) begin
      load_i = 3'b000;
      if (cyc == 72) begin
        load_i = 3'b001;
        div_i[0 +: W] = 8'd4;
      end
      en_i = (cyc >= 75 && cyc < 80) ? 3'b110 : 3'b111;
      step();
      check_val("p5_tick0", 32'(tick_o[0]), 32'(cyc == 73 || cyc == 82));
      check_val("p5_sig0", 32'(sig_o[0]), 32'(cyc < 82));
      check_val("p5_tick1", 32'(tick_o[1]), 32'h1);
    end
    load_i = 3'b000;
    en_i   = 3'b111;

    $display("[TB] phase 6: divisors 3/6/6, sync, then reset");
    load_i = 3'b111;
    div_i  = {8'd6, 8'd6, 8'd3};
    step();
    load_i = 3'b000;
    while (cyc < 89) step();
    sync_i = 1'b1;
    en_i   = 3'b011;   // sync must act on a disabled channel too
    step();
    sync_i = 1'b0;
    en_i   = 3'b111;
    s_cyc  = cyc;
    check_val("sync_tick", 32'(tick_o), 32'h0);
    check_val("sync_sig", 32'(sig_o), 32'h0);
    for (int i = 1; i <= 13; i++) begin
      step();
      k = cyc - s_cyc;
      exp_t[0] = (k % 3 == 0);
      exp_t[1] = (k % 6 == 0);
      exp_t[2] = (k % 6 == 0);
      exp_s[0] = ((k / 3) % 2 == 1);
      exp_s[1] = ((k / 6) % 2 == 1);
      exp_s[2] = ((k / 6) % 2 == 1);
      check_val("p6_tick", 32'(tick_o), 32'(exp_t));
      check_val("p6_sig", 32'(sig_o), 32'(exp_s));
    end

    rst = 1'b1;
    step();
    check_val("mid_rst_tick", 32'(tick_o), 32'h0);
    check_val("mid_rst_sig", 32'(sig_o), 32'h0);
    rst = 1'b0;
    cyc = 0;
    while (cyc < 4) begin
      step();
      check_val("post_rst_tick", 32'(tick_o), (cyc == 4) ? 32'h7 : 32'h0);
      check_val("post_rst_sig", 32'(sig_o), (cyc == 4) ? 32'h7 : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
